// File: rtl/clock_period_meter.sv
// Measures the period and high time of a slow square wave in input_clock cycles.
// Also emits edge strobes and flags loss of the wave after a programmable timeout.
module clock_period_meter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             input_clock,
    input  logic             reset,
    input  logic             sample_in,
    input  logic [CNT_W-1:0] timeout_limit,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_strobe,
    output logic             locked,
    output logic             clock_lost
);

    localparam int unsigned      LAST    = SYNC_STAGES - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [CNT_W-1:0]       cnt_q;

    logic                   rise_c;
    logic                   fall_c;
    logic                   timeout_c;
    logic [CNT_W-1:0]       cnt_inc_c;

    // Edge detect, saturating increment and timeout compare.
    always_comb begin
        rise_c    = sync_q[LAST] & ~hist_q;
        fall_c    = ~sync_q[LAST] & hist_q;
        cnt_inc_c = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
        timeout_c = (timeout_limit != '0) && (cnt_q == timeout_limit - CNT_W'(1));
    end

    always_ff @(posedge input_clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            sync_q        <= '0;
            hist_q        <= 1'b0;
            cnt_q         <= '0;
            rise_pulse    <= 1'b0;
            fall_pulse    <= 1'b0;
            period        <= '0;
            high_time     <= '0;
            period_strobe <= 1'b0;
            locked        <= 1'b0;
            clock_lost    <= 1'b0;
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], sample_in};
            hist_q        <= sync_q[LAST];
            rise_pulse    <= rise_c;
            fall_pulse    <= fall_c;
            period_strobe <= 1'b0;
            cnt_q         <= rise_c ? '0 : cnt_inc_c;

            // Measured values are the clamped cycle count up to and including this edge.
            if (fall_c && (state_q != ST_IDLE)) begin
                high_time <= cnt_inc_c;
            end

            // A rising edge always wins over a coincident timeout.
            if (rise_c) begin
                clock_lost <= 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_ARMED;
                    end
                    ST_ARMED, ST_LOCKED: begin
                        state_q       <= ST_LOCKED;
                        period        <= cnt_inc_c;
                        period_strobe <= 1'b1;
                        locked        <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end else if ((state_q != ST_IDLE) && timeout_c) begin
                state_q    <= ST_IDLE;
                clock_lost <= 1'b1;
                locked     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clock_period_meter.sv
// Randomized and directed bench for clock_period_meter.
// Checks every output each cycle against an elapsed-time reference model.
module tb_clock_period_meter;

    localparam int unsigned SS    = 2;
    localparam int unsigned CNT_W = 8;
    localparam int          MAXV  = (1 << CNT_W) - 1;

    logic             input_clock = 1'b0;
    logic             reset       = 1'b0;
    logic             sample_in   = 1'b0;
    logic [CNT_W-1:0] timeout_limit = '0;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_strobe;
    logic             locked;
    logic             clock_lost;

    clock_period_meter #(.SYNC_STAGES(SS), .CNT_W(CNT_W)) dut (
        .input_clock  (input_clock),
        .reset        (reset),
        .sample_in    (sample_in),
        .timeout_limit(timeout_limit),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .period       (period),
        .high_time    (high_time),
        .period_strobe(period_strobe),
        .locked       (locked),
        .clock_lost   (clock_lost)
    );

    always #5 input_clock = ~input_clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    endtask

    // Reference model: the DUT sees the wave SS samples late; measurements are
    // the number of clock edges elapsed since the last detected rising edge.
    bit               smp[$];
    int               e_idx;
    int               last_rise;
    int               phase;        // 0 idle, 1 armed, 2 locked
    logic             exp_rp, exp_fp, exp_ps, exp_lk, exp_cl;
    logic [CNT_W-1:0] exp_per, exp_ht;

    task automatic model_clear();
        smp = {};
        for (int i = 0; i <= int'(SS); i++) smp.push_back(1'b0);
        phase   = 0;
        exp_rp  = 0; exp_fp = 0; exp_ps = 0; exp_lk = 0; exp_cl = 0;
        exp_per = '0; exp_ht = '0;
    endtask

    task automatic model_edge();
        bit               r, f;
        int               el;
        logic [CNT_W-1:0] meas;
        e_idx++;
        smp.push_back(sample_in);
        r = smp[1] && !smp[0];
        f = !smp[1] && smp[0];
        void'(smp.pop_front());
        el     = e_idx - last_rise;
        meas   = (el > MAXV) ? CNT_W'(MAXV) : CNT_W'(el);
        exp_rp = r;
        exp_fp = f;
        exp_ps = 0;
        if (f && phase != 0) exp_ht = meas;
        if (r) begin
            exp_cl = 0;
            if (phase != 0) begin
                exp_per = meas; exp_ps = 1; exp_lk = 1; phase = 2;
            end else begin
                phase = 1;
            end
            last_rise = e_idx;
        end else if (phase != 0 && timeout_limit != '0 && el == int'(timeout_limit)) begin
            phase = 0; exp_cl = 1; exp_lk = 0;
        end
    endtask

    task automatic check_all();
        check("rise_pulse",    32'(rise_pulse),    32'(exp_rp));
        check("fall_pulse",    32'(fall_pulse),    32'(exp_fp));
        check("period",        32'(period),        32'(exp_per));
        check("high_time",     32'(high_time),     32'(exp_ht));
        check("period_strobe", 32'(period_strobe), 32'(exp_ps));
        check("locked",        32'(locked),        32'(exp_lk));
        check("clock_lost",    32'(clock_lost),    32'(exp_cl));
    endtask

    task automatic step();
        @(posedge input_clock);
        if (reset) model_edge();
        #1;
        check_all();
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < hi; i++) begin sample_in = 1'b1; step(); end
            for (int i = 0; i < lo; i++) begin sample_in = 1'b0; step(); end
        end
    endtask

    // Asynchronous reset between edges; outputs must clear before the next edge.
    task automatic async_reset(input int hold);
        #2;
        reset = 1'b0;
        #1;
        check("rst_rise_pulse", 32'(rise_pulse),    32'd0);
        check("rst_fall_pulse", 32'(fall_pulse),    32'd0);
        check("rst_period",     32'(period),        32'd0);
        check("rst_high_time",  32'(high_time),     32'd0);
        check("rst_strobe",     32'(period_strobe), 32'd0);
        check("rst_locked",     32'(locked),        32'd0);
        check("rst_lost",       32'(clock_lost),    32'd0);
        model_clear();
        for (int i = 0; i < hold; i++) step();
        #2;
        reset = 1'b1;
    endtask

    initial begin
        int n;
        bit seen;
        e_idx     = 0;
        last_rise = 0;
        model_clear();

        // Reset state
        for (int i = 0; i < 3; i++) step();
        #2 reset = 1'b1;

        // Divider 4, no timeout
        wave(2, 2, 5);
        wave(0, 3, 1);

        // Odd divider with explicit edge-latency check
        async_reset(2);
        wave(0, 3, 1);
        sample_in = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            step();
            n++;
            seen = rise_pulse;
        end
        check("rise_latency", 32'(n), 32'd3);
        wave(0, 3, 1);
        wave(2, 3, 5);

        // Minimum period
        wave(1, 1, 10);

        // Timeout then recovery with period 6
        timeout_limit = CNT_W'(20);
        wave(2, 2, 3);
        wave(0, 30, 1);
        wave(1, 5, 3);

        // Rising edge coincides with timeout compare
        timeout_limit = CNT_W'(8);
        wave(4, 4, 6);

        // Reset mid-high-phase while locked, then relock with period 4
        timeout_limit = '0;
        wave(2, 2, 4);
        sample_in = 1'b1;
        step();
        step();
        step();
        async_reset(2);
        wave(2, 2, 4);

        // Saturation of long low and long high phases
        wave(1, 300, 2);
        wave(300, 2, 2);

        // Randomized wave shapes and live timeout changes
        for (int p = 0; p < 150; p++) begin
            int hi, lo;
            if ($urandom_range(0, 9) == 0)
                timeout_limit = ($urandom_range(0, 3) == 0) ? '0 : CNT_W'($urandom_range(8, 30));
            hi = int'($urandom_range(1, 6));
            lo = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 45)) : int'($urandom_range(1, 6));
            wave(hi, lo, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
